// File: rtl/spmm_pe_scheduler_if.sv
// Entry stream, weight-load port, PE operand bus and result beat of spmm_pe_scheduler.
// master = scheduler side; slave = environment (entry source, PE pair, result sink).
interface spmm_pe_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 7,
  parameter int COL_W  = 5
);
  logic              i_w_we;
  logic              i_w_bank;
  logic [COL_W-1:0]  i_w_addr;
  logic [DATA_W-1:0] i_w_data;
  logic              i_start;
  logic              i_valid;
  logic              o_in_ready;
  logic [ROW_W-1:0]  i_row;
  logic [COL_W-1:0]  i_col;
  logic [DATA_W-1:0] i_data;
  logic              i_last;
  logic              o_pe_ctrl;
  logic [DATA_W-1:0] o_pe_ipt;
  logic [DATA_W-1:0] o_pe1_wgt;
  logic [DATA_W-1:0] o_pe2_wgt;
  logic [DATA_W-1:0] i_pe1_result;
  logic [DATA_W-1:0] i_pe2_result;
  logic              o_valid;
  logic              i_out_ready;
  logic [ROW_W-1:0]  o_row;
  logic [DATA_W-1:0] o_res1;
  logic [DATA_W-1:0] o_res2;
  logic              o_done;

  modport master (
    input  i_w_we, i_w_bank, i_w_addr, i_w_data, i_start,
    input  i_valid, i_row, i_col, i_data, i_last,
    input  i_pe1_result, i_pe2_result, i_out_ready,
    output o_in_ready, o_pe_ctrl, o_pe_ipt, o_pe1_wgt, o_pe2_wgt,
    output o_valid, o_row, o_res1, o_res2, o_done
  );

  modport slave (
    output i_w_we, i_w_bank, i_w_addr, i_w_data, i_start,
    output i_valid, i_row, i_col, i_data, i_last,
    output i_pe1_result, i_pe2_result, i_out_ready,
    input  o_in_ready, o_pe_ctrl, o_pe_ipt, o_pe1_wgt, o_pe2_wgt,
    input  o_valid, o_row, o_res1, o_res2, o_done
  );
endinterface

// File: rtl/spmm_pe_scheduler.sv
// Row sequencer for the first-layer PE pair: streams sorted sparse entries into two lock-step PEs
// and emits one (row, res1, res2) beat per non-empty row. Define SCHED_STATS_EN for MAC/row counters.
module spmm_pe_scheduler #(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 7,
  parameter int COL_W  = 5,
  parameter int PE_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  spmm_pe_scheduler_if.master bus
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]         o_mac_cnt,
  output logic [ROW_W:0]      o_row_cnt
`endif
);
  localparam int CNT_W = $clog2(PE_LAT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_EMIT,
    S_CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic              row_open_q, row_open_d;
  logic [ROW_W-1:0]  cur_row_q, cur_row_d;
  logic              pend_vld_q, pend_vld_d;
  logic [ROW_W-1:0]  pend_row_q, pend_row_d;
  logic [COL_W-1:0]  pend_col_q, pend_col_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              pend_last_q, pend_last_d;
  logic              iss_vld_q, iss_vld_d;
  logic [DATA_W-1:0] iss_data_q, iss_data_d;
  logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;

  logic              rd_en;
  logic [COL_W-1:0]  rd_addr;
  logic              accept;
  logic              same_row;
  logic              w_we_ok;
  logic              start_acc;
  logic              beat_done;

  assign accept    = (state_q == S_RUN) && bus.i_valid;
  assign same_row  = !row_open_q || (bus.i_row == cur_row_q);
  assign w_we_ok   = (state_q == S_IDLE) && bus.i_w_we;
  assign start_acc = (state_q == S_IDLE) && bus.i_start;
  assign beat_done = (state_q == S_EMIT) && bus.i_out_ready;

  // Weight banks read one cycle ahead so the operand lines up with the issue stage.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [DATA_W-1:0] mem [2**COL_W];
    logic [DATA_W-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (w_we_ok && (bus.i_w_bank == 1'(gi))) begin
        mem[bus.i_w_addr] <= bus.i_w_data;
      end
      if (rd_en) begin
        rd_q <= mem[rd_addr];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    row_open_d   = row_open_q;
    cur_row_d    = cur_row_q;
    pend_vld_d   = pend_vld_q;
    pend_row_d   = pend_row_q;
    pend_col_d   = pend_col_q;
    pend_data_d  = pend_data_q;
    pend_last_d  = pend_last_q;
    iss_vld_d    = 1'b0;
    iss_data_d   = '0;
    settle_cnt_d = settle_cnt_q;
    rd_en        = 1'b0;
    rd_addr      = bus.i_col;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d    = S_RUN;
          row_open_d = 1'b0;
          pend_vld_d = 1'b0;
        end
      end
      S_RUN: begin
        if (accept) begin
          settle_cnt_d = '0;
          if (same_row) begin
            iss_vld_d  = 1'b1;
            iss_data_d = bus.i_data;
            rd_en      = 1'b1;
            cur_row_d  = bus.i_row;
            row_open_d = 1'b1;
            if (bus.i_last) begin
              state_d = S_SETTLE;
            end
          end else begin
            // Any row change, upward or downward, closes the open row first.
            pend_vld_d  = 1'b1;
            pend_row_d  = bus.i_row;
            pend_col_d  = bus.i_col;
            pend_data_d = bus.i_data;
            pend_last_d = bus.i_last;
            state_d     = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == CNT_W'(PE_LAT)) begin
          state_d = S_EMIT;
        end else begin
          settle_cnt_d = settle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_EMIT: begin
        if (bus.i_out_ready) begin
          state_d    = S_CLEAR;
          row_open_d = 1'b0;
        end
      end
      S_CLEAR: begin
        if (pend_vld_q) begin
          iss_vld_d    = 1'b1;
          iss_data_d   = pend_data_q;
          rd_en        = 1'b1;
          rd_addr      = pend_col_q;
          cur_row_d    = pend_row_q;
          row_open_d   = 1'b1;
          pend_vld_d   = 1'b0;
          settle_cnt_d = '0;
          state_d      = pend_last_q ? S_SETTLE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      row_open_q   <= 1'b0;
      cur_row_q    <= '0;
      pend_vld_q   <= 1'b0;
      pend_row_q   <= '0;
      pend_col_q   <= '0;
      pend_data_q  <= '0;
      pend_last_q  <= 1'b0;
      iss_vld_q    <= 1'b0;
      iss_data_q   <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      row_open_q   <= row_open_d;
      cur_row_q    <= cur_row_d;
      pend_vld_q   <= pend_vld_d;
      pend_row_q   <= pend_row_d;
      pend_col_q   <= pend_col_d;
      pend_data_q  <= pend_data_d;
      pend_last_q  <= pend_last_d;
      iss_vld_q    <= iss_vld_d;
      iss_data_q   <= iss_data_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // An open row with an empty issue stage yields a bubble (ctrl=1, zero operands).
  assign bus.o_in_ready = (state_q == S_RUN);
  assign bus.o_pe_ctrl  = iss_vld_q || row_open_q;
  assign bus.o_pe_ipt   = iss_data_q;
  assign bus.o_pe1_wgt  = iss_vld_q ? g_bank[0].rd_q : '0;
  assign bus.o_pe2_wgt  = iss_vld_q ? g_bank[1].rd_q : '0;
  assign bus.o_valid    = (state_q == S_EMIT);
  assign bus.o_row      = (state_q == S_EMIT) ? cur_row_q : '0;
  assign bus.o_res1     = (state_q == S_EMIT) ? bus.i_pe1_result : '0;
  assign bus.o_res2     = (state_q == S_EMIT) ? bus.i_pe2_result : '0;
  assign bus.o_done     = (state_q == S_CLEAR) && !pend_vld_q;

`ifdef SCHED_STATS_EN
  logic [15:0]    mac_cnt_q, mac_cnt_d;
  logic [ROW_W:0] row_cnt_q, row_cnt_d;

  always_comb begin
    mac_cnt_d = mac_cnt_q;
    row_cnt_d = row_cnt_q;
    if (start_acc) begin
      mac_cnt_d = '0;
      row_cnt_d = '0;
    end else begin
      if (iss_vld_q && !(&mac_cnt_q)) begin
        mac_cnt_d = mac_cnt_q + 16'd1;
      end
      if (beat_done && !(&row_cnt_q)) begin
        row_cnt_d = row_cnt_q + {{ROW_W{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_cnt_q <= '0;
      row_cnt_q <= '0;
    end else begin
      mac_cnt_q <= mac_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  assign o_mac_cnt = mac_cnt_q;
  assign o_row_cnt = row_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = start_acc ^ beat_done;
`endif
endmodule

// File: tb/tb_spmm_pe_scheduler.sv
// Directed bench for spmm_pe_scheduler with an ideal single-cycle PE pair on the operand bus.
module tb_spmm_pe_scheduler;
  localparam int DATA_W = 16;
  localparam int ROW_W  = 7;
  localparam int COL_W  = 5;
  localparam int PE_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  spmm_pe_scheduler_if #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

`ifdef SCHED_STATS_EN
  logic [15:0]    mac_cnt;
  logic [ROW_W:0] row_cnt;
`endif

  spmm_pe_scheduler #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W), .PE_LAT(PE_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master)
`ifdef SCHED_STATS_EN
    ,
    .o_mac_cnt (mac_cnt),
    .o_row_cnt (row_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Ideal PE: clear on ctrl=0, otherwise accumulate ipt*wgt; result visible next cycle.
  logic [DATA_W-1:0] acc1, acc2;
  always_ff @(posedge clk) begin
    if (!bus.o_pe_ctrl) begin
      acc1 <= '0;
      acc2 <= '0;
    end else begin
      acc1 <= acc1 + DATA_W'(bus.o_pe_ipt * bus.o_pe1_wgt);
      acc2 <= acc2 + DATA_W'(bus.o_pe_ipt * bus.o_pe2_wgt);
    end
  end
  assign bus.i_pe1_result = acc1;
  assign bus.i_pe2_result = acc2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic bank, input int addr, input int data);
    bus.i_w_we   = 1'b1;
    bus.i_w_bank = bank;
    bus.i_w_addr = COL_W'(addr);
    bus.i_w_data = DATA_W'(data);
    tick();
    bus.i_w_we = 1'b0;
    $display("wgt_write bank=%0d addr=%0d data=%0d", bank, addr, data);
  endtask

  task automatic start_pass();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    $display("start");
  endtask

  task automatic send_entry(input int row, input int col, input int data, input bit last);
    int n = 0;
    bus.i_valid = 1'b1;
    bus.i_row   = ROW_W'(row);
    bus.i_col   = COL_W'(col);
    bus.i_data  = DATA_W'(data);
    bus.i_last  = last;
    while (bus.o_in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (bus.o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL entry_ready: o_in_ready=%0b after %0d cycles, required 1", bus.o_in_ready, n);
    end
    $display("entry row=%0d col=%0d data=%0d last=%0b", row, col, data, last);
    tick();
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (bus.o_valid !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic take_beat();
    $display("beat row=%0d res1=%0d res2=%0d", bus.o_row, bus.o_res1, bus.o_res2);
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.o_valid, bus.o_in_ready, bus.o_pe_ctrl, bus.o_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl: valid/in_ready/ctrl/done=%b, required 0000",
               {bus.o_valid, bus.o_in_ready, bus.o_pe_ctrl, bus.o_done});
    end
    checks++;
    if ({bus.o_pe_ipt, bus.o_pe1_wgt, bus.o_pe2_wgt, bus.o_row, bus.o_res1, bus.o_res2} !== '0) begin
      errors++;
      $display("FAIL reset_data: ipt=%0d w1=%0d w2=%0d row=%0d r1=%0d r2=%0d, required all 0",
               bus.o_pe_ipt, bus.o_pe1_wgt, bus.o_pe2_wgt, bus.o_row, bus.o_res1, bus.o_res2);
    end
    #3 rst = 1'b1;
    tick();
    checks++;
    if (bus.o_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: o_in_ready=%0b, required 0", bus.o_in_ready);
    end
  endtask

  task automatic test_single();
    int n;
    write_w(1'b0, 3, 2);
    write_w(1'b1, 3, 5);
    start_pass();
    checks++;
    if (bus.o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_run_ready: o_in_ready=%0b, required 1", bus.o_in_ready);
    end
    send_entry(4, 3, 7, 1'b1);
    checks++;
    if ({bus.o_pe_ctrl, bus.o_pe_ipt, bus.o_pe1_wgt, bus.o_pe2_wgt} !== {1'b1, 16'd7, 16'd2, 16'd5}) begin
      errors++;
      $display("FAIL single_issue: ctrl=%0b ipt=%0d w1=%0d w2=%0d, required 1 7 2 5",
               bus.o_pe_ctrl, bus.o_pe_ipt, bus.o_pe1_wgt, bus.o_pe2_wgt);
    end
    checks++;
    if (bus.o_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_settle_ready: o_in_ready=%0b, required 0", bus.o_in_ready);
    end
    wait_valid(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL single_latency: valid after %0d cycles, required 2", n);
    end
    checks++;
    if ({bus.o_row, bus.o_res1, bus.o_res2} !== {7'd4, 16'd14, 16'd35}) begin
      errors++;
      $display("FAIL single_beat: row=%0d r1=%0d r2=%0d, required 4 14 35", bus.o_row, bus.o_res1, bus.o_res2);
    end
    take_beat();
    checks++;
    if ({bus.o_done, bus.o_pe_ctrl, bus.o_valid} !== 3'b100) begin
      errors++;
      $display("FAIL single_done: done/ctrl/valid=%b, required 100", {bus.o_done, bus.o_pe_ctrl, bus.o_valid});
    end
    tick();
    checks++;
    if ({bus.o_done, bus.o_in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: done/in_ready=%b, required 00", {bus.o_done, bus.o_in_ready});
    end
  endtask

  task automatic test_row_gap();
    int n;
    write_w(1'b0, 1, 10);
    write_w(1'b0, 2, 20);
    write_w(1'b1, 1, 3);
    write_w(1'b1, 2, 4);
    start_pass();
    send_entry(0, 1, 1, 1'b0);
    send_entry(0, 2, 3, 1'b0);
    send_entry(2, 1, 2, 1'b1);
    wait_valid(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL gap_latency: valid after %0d cycles, required 2", n);
    end
    checks++;
    if ({bus.o_row, bus.o_res1, bus.o_res2} !== {7'd0, 16'd70, 16'd15}) begin
      errors++;
      $display("FAIL gap_beat0: row=%0d r1=%0d r2=%0d, required 0 70 15", bus.o_row, bus.o_res1, bus.o_res2);
    end
    take_beat();
    checks++;
    if ({bus.o_done, bus.o_pe_ctrl, bus.o_valid} !== 3'b000) begin
      errors++;
      $display("FAIL gap_clear: done/ctrl/valid=%b, required 000", {bus.o_done, bus.o_pe_ctrl, bus.o_valid});
    end
    tick();
    checks++;
    if ({bus.o_pe_ctrl, bus.o_pe_ipt, bus.o_pe1_wgt, bus.o_pe2_wgt} !== {1'b1, 16'd2, 16'd10, 16'd3}) begin
      errors++;
      $display("FAIL gap_pend_issue: ctrl=%0b ipt=%0d w1=%0d w2=%0d, required 1 2 10 3",
               bus.o_pe_ctrl, bus.o_pe_ipt, bus.o_pe1_wgt, bus.o_pe2_wgt);
    end
    wait_valid(n);
    checks++;
    if ({bus.o_row, bus.o_res1, bus.o_res2} !== {7'd2, 16'd20, 16'd6}) begin
      errors++;
      $display("FAIL gap_beat2: row=%0d r1=%0d r2=%0d, required 2 20 6", bus.o_row, bus.o_res1, bus.o_res2);
    end
    take_beat();
    checks++;
    if (bus.o_done !== 1'b1) begin
      errors++;
      $display("FAIL gap_done: o_done=%0b, required 1", bus.o_done);
    end
    tick();
  endtask

  task automatic test_stall();
    int n;
    start_pass();
    send_entry(9, 3, 4, 1'b1);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.o_valid, bus.o_row, bus.o_res1, bus.o_res2} !== {1'b1, 7'd9, 16'd8, 16'd20}) begin
        errors++;
        $display("FAIL stall_beat[%0d]: valid=%0b row=%0d r1=%0d r2=%0d, required 1 9 8 20",
                 i, bus.o_valid, bus.o_row, bus.o_res1, bus.o_res2);
      end
      checks++;
      if ({bus.o_in_ready, bus.o_pe_ctrl, bus.o_pe_ipt, bus.o_pe1_wgt, bus.o_pe2_wgt} !== {1'b0, 1'b1, 48'd0}) begin
        errors++;
        $display("FAIL stall_bubble[%0d]: in_ready=%0b ctrl=%0b ipt=%0d w1=%0d w2=%0d, required 0 1 0 0 0",
                 i, bus.o_in_ready, bus.o_pe_ctrl, bus.o_pe_ipt, bus.o_pe1_wgt, bus.o_pe2_wgt);
      end
      tick();
    end
    take_beat();
    checks++;
    if (bus.o_done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: o_done=%0b, required 1", bus.o_done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    start_pass();
    send_entry(5, 3, 1, 1'b0);
    send_entry(2, 1, 1, 1'b1);
    wait_valid(n);
    checks++;
    if ({bus.o_row, bus.o_res1, bus.o_res2} !== {7'd5, 16'd2, 16'd5}) begin
      errors++;
      $display("FAIL b2b_beat5: row=%0d r1=%0d r2=%0d, required 5 2 5", bus.o_row, bus.o_res1, bus.o_res2);
    end
    take_beat();
    checks++;
    if ({bus.o_pe_ctrl, bus.o_valid, bus.o_done} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_clear: ctrl/valid/done=%b, required 000", {bus.o_pe_ctrl, bus.o_valid, bus.o_done});
    end
    wait_valid(n);
    checks++;
    if ({bus.o_row, bus.o_res1, bus.o_res2} !== {7'd2, 16'd10, 16'd3}) begin
      errors++;
      $display("FAIL b2b_beat2: row=%0d r1=%0d r2=%0d, required 2 10 3", bus.o_row, bus.o_res1, bus.o_res2);
    end
    take_beat();
    checks++;
    if (bus.o_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: o_done=%0b, required 1", bus.o_done);
    end
    tick();
  endtask

  task automatic test_weight_write_run();
    int n;
    start_pass();
    write_w(1'b0, 3, 99);
    write_w(1'b1, 3, 77);
    send_entry(1, 3, 3, 1'b1);
    checks++;
    if ({bus.o_pe1_wgt, bus.o_pe2_wgt} !== {16'd2, 16'd5}) begin
      errors++;
      $display("FAIL wrun_wgt: w1=%0d w2=%0d, required 2 5", bus.o_pe1_wgt, bus.o_pe2_wgt);
    end
    wait_valid(n);
    checks++;
    if ({bus.o_row, bus.o_res1, bus.o_res2} !== {7'd1, 16'd6, 16'd15}) begin
      errors++;
      $display("FAIL wrun_beat: row=%0d r1=%0d r2=%0d, required 1 6 15", bus.o_row, bus.o_res1, bus.o_res2);
    end
    take_beat();
    tick();
  endtask

  task automatic test_reset_mid_run();
    int n;
    start_pass();
    send_entry(3, 3, 1, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.o_valid, bus.o_in_ready, bus.o_pe_ctrl, bus.o_done, bus.o_pe_ipt, bus.o_pe1_wgt,
         bus.o_pe2_wgt, bus.o_row, bus.o_res1, bus.o_res2} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%0b in_ready=%0b ctrl=%0b ipt=%0d w1=%0d row=%0d, required all 0",
               bus.o_valid, bus.o_in_ready, bus.o_pe_ctrl, bus.o_pe_ipt, bus.o_pe1_wgt, bus.o_row);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    checks++;
    if ({bus.o_in_ready, bus.o_pe_ctrl} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_idle: in_ready/ctrl=%b, required 00", {bus.o_in_ready, bus.o_pe_ctrl});
    end
    write_w(1'b0, 3, 2);
    write_w(1'b1, 3, 5);
    start_pass();
    send_entry(6, 3, 2, 1'b1);
    wait_valid(n);
    checks++;
    if ({bus.o_row, bus.o_res1, bus.o_res2} !== {7'd6, 16'd4, 16'd10}) begin
      errors++;
      $display("FAIL midrst_beat: row=%0d r1=%0d r2=%0d, required 6 4 10", bus.o_row, bus.o_res1, bus.o_res2);
    end
    take_beat();
    checks++;
    if (bus.o_done !== 1'b1) begin
      errors++;
      $display("FAIL midrst_done: o_done=%0b, required 1", bus.o_done);
    end
    tick();
  endtask

  initial begin
    rst             = 1'b0;
    bus.i_w_we      = 1'b0;
    bus.i_w_bank    = 1'b0;
    bus.i_w_addr    = '0;
    bus.i_w_data    = '0;
    bus.i_start     = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_row       = '0;
    bus.i_col       = '0;
    bus.i_data      = '0;
    bus.i_last      = 1'b0;
    bus.i_out_ready = 1'b0;
    test_reset();
    test_single();
    test_row_gap();
    test_stall();
    test_back_to_back();
    test_weight_write_run();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spmm_pe_scheduler.md
# spmm_pe_scheduler

Sequencer for the first-layer PE pair of the GCN datapath. It consumes a row-sorted sparse (COO/CSR-order) input stream and holds two weight columns in local banks. It drives both PEs in lock-step, using the PE inner-accumulate control so that PE1 computes one row of X·W[:,c0] and PE2 the same row of X·W[:,c1]. Each completed row is emitted as a (row, result1, result2) beat toward the second-stage scheduler.

## Interface
- DATA_W, 16, data/weight width
- ROW_W, 7, row index width
- COL_W, 5, column index width (weight bank depth = 2^COL_W)
- PE_LAT, 1, cycles from a MAC issue cycle until the PE result is visible
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_w_we / i_w_bank / i_w_addr / i_w_data  in  1/1/COL_W/DATA_W  weight write: bank 0 → PE1, bank 1 → PE2
- i_start  in  1  begin a matrix pass
- i_valid / o_in_ready  in/out  1/1  entry handshake
- i_row / i_col / i_data / i_last  in  ROW_W/COL_W/DATA_W/1  entry fields; i_last marks the final entry of the pass
- o_pe_ctrl  out  1  PE InnerAccum control: 1 = accumulate, 0 = clear
- o_pe_ipt  out  DATA_W  input operand to both PEs
- o_pe1_wgt / o_pe2_wgt  out  DATA_W  weight operands
- i_pe1_result / i_pe2_result  in  DATA_W  PE accumulators
- o_valid / i_out_ready  out/in  1/1  result handshake
- o_row / o_res1 / o_res2  out  ROW_W/DATA_W/DATA_W  result beat
- o_done  out  1  one-cycle pulse at end of pass

## Operation
- All outputs reset to 0. All state clears asynchronously on rst low, including mid-pass. After reset the state is IDLE.
- Weight writes take effect only in IDLE. Writes in any other state are ignored.
- The PE holds its accumulator by receiving ctrl=1 with ipt=0 and wgt=0 (a "bubble"). ctrl=0 is driven only when no row is open.
- IDLE: ctrl=0, o_in_ready=0. i_start moves to RUN with row_open=0. i_start is ignored in all other states.
- RUN: o_in_ready=1.
  - An accepted entry E with !row_open or E.row==cur_row is registered into the issue stage and becomes cur_row; row_open is set.
  - If E.last, go to SETTLE with pending empty.
  - If row_open and E.row!=cur_row (including a lower row), E is stored in the pending register and the state goes to SETTLE.
- Issue stage: one cycle after acceptance, drive ctrl=1, ipt=E.data, pe1_wgt=bank0[E.col], pe2_wgt=bank1[E.col]. The issue stage drives a bubble if it is empty and a row is open, and ctrl=0 if it is empty and no row is open.
- SETTLE: o_in_ready=0; lasts PE_LAT+1 cycles (counter), then go to EMIT.
- EMIT: o_valid=1, o_row=cur_row, o_res1/o_res2 follow the PE results. PEs receive bubbles. On i_out_ready, go to CLEAR.
- CLEAR: one cycle with ctrl=0; row_open=0.
  - If pending: issue the pending entry next cycle, set cur_row, and return to RUN, or to SETTLE if the pending entry is last.
  - Otherwise: pulse o_done and go to IDLE.
- Rows with no entries are never emitted. Output order is arrival order.
- Arithmetic (multiply, accumulate, overflow) belongs to the PE. This block passes operands unmodified.

## Timing
- Entry accepted at cycle t → MAC issued at t+1 → result visible at t+1+PE_LAT.
- Last same-row accept at t, new-row accept at t+1 → SETTLE during t+2..t+2+PE_LAT, o_valid from t+3+PE_LAT.
- In EMIT, o_valid stays high and o_row, o_res1, o_res2 stay stable until i_out_ready. The handshake completes on the cycle both are high.
- Throughput is one entry per cycle within a row. Each row change costs PE_LAT+3 cycles plus output stall.
- An i_valid arriving in the same cycle as the transition out of RUN is not accepted, because o_in_ready is registered low.

## Configuration
- SCHED_STATS_EN defined: adds outputs o_mac_cnt (16b, counts issued non-bubble MACs) and o_row_cnt (ROW_W+1 b, counts emitted rows). Both counters clear on accepted i_start and saturate at all-ones.
- Undefined: these ports and their counters are absent, and all other behaviour is identical.

## Test plan
- Load bank0[3]=2 and bank1[3]=5, then send one entry (row 4, col 3, data 7, last) → PE ops (ctrl=1, ipt 7, wgts 2/5). Beat: row 4, res 14/35 with an ideal PE. Then o_done.
- Row 0 entries (col1, d1) and (col2, d3) with bank0={_,10,20} → single beat row 0, res1=70. No beat for the empty row 1 before a row-2 entry.
- Hold i_out_ready=0 for 10 cycles during EMIT → o_valid and data stay stable, o_in_ready=0, PE receives ctrl=1 bubbles, and the accumulator is unchanged.
- Send rows 5, 2 (decreasing) → two beats in order 5, 2, with a CLEAR between them.
- Assert rst mid-RUN → all outputs 0 immediately, state IDLE, and the next i_start behaves as a fresh pass.
- Weight write during RUN → ignored, and the MAC issued afterwards uses the previous weight value.
